// File: rtl/spinner_mc_if.sv
// rtl/spinner_mc_if.sv - motion inputs, frame strobe and position/source outputs of spinner_mc
interface spinner_mc_if #(
   parameter int CHANNELS = 2,
   parameter int OUT_W    = 8
);
   logic                       strobe;
   logic [CHANNELS-1:0]        minus;
   logic [CHANNELS-1:0]        plus;
   logic [CHANNELS-1:0]        fast;
   logic [9*CHANNELS-1:0]      spin_in;
   logic [8:0]                 mouse_in;
   logic [CHANNELS-1:0]        clamp_en;
   logic [OUT_W*CHANNELS-1:0]  spin_out;
   logic [2*CHANNELS-1:0]      src_sel;

   modport master (
      output strobe, minus, plus, fast, spin_in, mouse_in, clamp_en,
      input  spin_out, src_sel
   );

   modport slave (
      input  strobe, minus, plus, fast, spin_in, mouse_in, clamp_en,
      output spin_out, src_sel
   );
endinterface

// File: rtl/spinner_mc.sv
// rtl/spinner_mc.sv - multi-channel spinner/paddle position generator with per-frame wrap or clamp
module spinner_mc #(
   parameter int CHANNELS  = 2,
   parameter int OUT_W     = 8,
   parameter int DIG_STEP  = 1,
   parameter int FAST_STEP = 4,
   parameter int LIMIT_LO  = 0,
   parameter int LIMIT_HI  = 2**OUT_W-1,
   parameter int RESET_VAL = 0
)(
   input  logic         clk,
   input  logic         reset_n,
   spinner_mc_if.slave  bus
);
   localparam int PW     = OUT_W + 2;
   localparam int SW     = OUT_W + 3;
   localparam int PMAX_I = (1 << (OUT_W + 1)) - 1;

   localparam logic signed [PW:0]   A_MAX = (PW+1)'(PMAX_I);
   localparam logic signed [PW:0]   A_MIN = (PW+1)'(-PMAX_I);
   localparam logic signed [SW-1:0] LO_S  = SW'(LIMIT_LO);
   localparam logic signed [SW-1:0] HI_S  = SW'(LIMIT_HI);

   logic r_armed;
   logic r_strobe_q;
   logic r_mtog_q;
   logic w_frame;
   logic w_mouse_ev;

   assign w_frame    = bus.strobe & ~r_strobe_q;
   assign w_mouse_ev = r_armed & (bus.mouse_in[8] ^ r_mtog_q);

   // Toggle history always tracks the inputs; events are masked until armed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_armed    <= 1'b0;
         r_strobe_q <= 1'b0;
         r_mtog_q   <= 1'b0;
      end else begin
         r_armed    <= 1'b1;
         r_strobe_q <= bus.strobe;
         r_mtog_q   <= bus.mouse_in[8];
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic                    r_tog_q;
      logic                    r_plus_q;
      logic                    r_minus_q;
      logic signed [PW-1:0]    r_pend;
      logic [OUT_W-1:0]        r_pos;
      logic [1:0]              r_sel;
      logic                    w_spin_ev;
      logic                    w_mouse_take;
      logic                    w_ev;
      logic                    w_btn_edge;
      logic [7:0]              w_raw;
      logic signed [PW-1:0]    w_delta;
      logic signed [PW:0]      w_acc_sum;
      logic signed [PW-1:0]    w_acc_sat;
      logic signed [SW-1:0]    w_dig;
      logic signed [SW-1:0]    w_sum;
      logic [OUT_W-1:0]        w_new_pos;

      assign w_spin_ev = r_armed & (bus.spin_in[9*c+8] ^ r_tog_q);

      // Spinner beats mouse on channel 0 when both arrive together.
      if (c == 0) begin : g_mouse
         assign w_mouse_take = w_mouse_ev & ~w_spin_ev;
      end else begin : g_no_mouse
         assign w_mouse_take = 1'b0;
      end

      assign w_ev       = w_spin_ev | w_mouse_take;
      assign w_btn_edge = (bus.plus[c] & ~r_plus_q) | (bus.minus[c] & ~r_minus_q);
      assign w_raw      = w_spin_ev ? bus.spin_in[9*c +: 8] :
                          (w_mouse_take ? bus.mouse_in[7:0] : 8'h00);
      assign w_delta    = {{(PW-8){w_raw[7]}}, w_raw};
      assign w_acc_sum  = $signed({r_pend[PW-1], r_pend}) + $signed({w_delta[PW-1], w_delta});

      always_comb begin
         w_acc_sat = w_acc_sum[PW-1:0];
         if (w_acc_sum > A_MAX)
            w_acc_sat = A_MAX[PW-1:0];
         else if (w_acc_sum < A_MIN)
            w_acc_sat = A_MIN[PW-1:0];
      end

      always_comb begin
         w_dig = '0;
         if (bus.plus[c] & ~bus.minus[c])
            w_dig = bus.fast[c] ? SW'(FAST_STEP) : SW'(DIG_STEP);
         else if (bus.minus[c] & ~bus.plus[c])
            w_dig = bus.fast[c] ? -SW'(FAST_STEP) : -SW'(DIG_STEP);
      end

      assign w_sum = $signed({3'b000, r_pos}) + $signed({r_pend[PW-1], r_pend}) + w_dig;

      always_comb begin
         w_new_pos = w_sum[OUT_W-1:0];
         if (bus.clamp_en[c]) begin
            if (w_sum > HI_S)
               w_new_pos = OUT_W'(LIMIT_HI);
            else if (w_sum < LO_S)
               w_new_pos = OUT_W'(LIMIT_LO);
         end
      end

      // An event coinciding with the frame edge seeds the next frame's motion.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_tog_q   <= 1'b0;
            r_plus_q  <= 1'b0;
            r_minus_q <= 1'b0;
            r_pend    <= '0;
            r_pos     <= OUT_W'(RESET_VAL);
            r_sel     <= 2'd0;
         end else begin
            r_tog_q   <= bus.spin_in[9*c+8];
            r_plus_q  <= bus.plus[c];
            r_minus_q <= bus.minus[c];
            if (w_spin_ev)
               r_sel <= 2'd1;
            else if (w_mouse_take)
               r_sel <= 2'd2;
            else if (w_btn_edge)
               r_sel <= 2'd0;
            if (w_frame) begin
               r_pos  <= w_new_pos;
               r_pend <= w_ev ? w_delta : '0;
            end else if (w_ev) begin
               r_pend <= w_acc_sat;
            end
         end
      end

      assign bus.spin_out[c*OUT_W +: OUT_W] = r_pos;
      assign bus.src_sel[2*c +: 2]          = r_sel;
   end
endmodule

// File: tb/tb_spinner_mc.sv
// tb/tb_spinner_mc.sv - directed vector bench for spinner_mc
module tb_spinner_mc;
   localparam int CH = 2;
   localparam int OW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   spinner_mc_if #(.CHANNELS(CH), .OUT_W(OW)) bus ();

   spinner_mc #(
      .CHANNELS(CH), .OUT_W(OW), .DIG_STEP(1), .FAST_STEP(4),
      .LIMIT_LO(16), .LIMIT_HI(240), .RESET_VAL(0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   typedef struct {
      logic p;
      logic m;
      logic f;
      logic ev;
      int   d;
      int   pos;
      int   sel;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int pos_of(input int c);
      return int'(bus.spin_out[c*OW +: OW]);
   endfunction

   function automatic int sel_of(input int c);
      return int'(bus.src_sel[2*c +: 2]);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic spin_ev(input int c, input int d);
      logic [7:0] dv;
      dv = 8'(d);
      bus.spin_in[9*c+8] = ~bus.spin_in[9*c+8];
      bus.spin_in[9*c +: 8] = dv;
   endtask

   task automatic mouse_ev(input int d);
      bus.mouse_in[8] = ~bus.mouse_in[8];
      bus.mouse_in[7:0] = 8'(d);
   endtask

   task automatic frame();
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
   endtask

   initial begin
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,   0,   1, 0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   0,   2, 0};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,   0,   3, 0};
      vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0,   0,   7, 0};
      vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0,   0,  11, 0};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,   0,  11, 0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,   0,  10, 0};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, -10, 252, 1};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1,  20,  17, 1};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,   0,  17, 1};
      vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0,   0,  18, 0};

      bus.strobe   = 1'b0;
      bus.minus    = '0;
      bus.plus     = '0;
      bus.fast     = '0;
      bus.spin_in  = '0;
      bus.spin_in[8] = 1'b1;
      bus.mouse_in = '0;
      bus.clamp_en = '0;

      // reset and arm with channel 0 toggle already high
      repeat (3) tick();
      chk("reset_pos0", pos_of(0), 0);
      chk("reset_sel", int'(bus.src_sel), 0);
      reset_n = 1'b1;
      repeat (2) tick();
      frame();
      tick();
      chk("arm_pos0", pos_of(0), 0);
      chk("arm_pos1", pos_of(1), 0);
      chk("arm_sel", int'(bus.src_sel), 0);

      // channel 1 accumulate and wrap
      for (int i = 0; i < 3; i++) begin
         spin_ev(1, 100);
         tick();
      end
      chk("ch1_sel_pre", sel_of(1), 1);
      frame();
      chk("ch1_wrap_pos", pos_of(1), 44);
      chk("ch1_wrap_ch0", pos_of(0), 0);

      // digital buttons and mixed spinner vectors on channel 0
      for (int i = 0; i < 11; i++) begin
         bus.plus[0]  = vt[i].p;
         bus.minus[0] = vt[i].m;
         bus.fast[0]  = vt[i].f;
         if (vt[i].ev) spin_ev(0, vt[i].d);
         tick();
         frame();
         chk($sformatf("vec%0d_pos", i), pos_of(0), vt[i].pos);
         chk($sformatf("vec%0d_sel", i), sel_of(0), vt[i].sel);
      end
      bus.plus[0] = 1'b0;
      tick();

      // move to 0x20 then clamp
      spin_ev(0, 14);
      tick();
      frame();
      chk("pre_clamp_pos", pos_of(0), 32);
      bus.clamp_en[0] = 1'b1;
      spin_ev(0, -128);
      tick();
      frame();
      chk("clamp_lo", pos_of(0), 16);
      for (int i = 0; i < 4; i++) begin
         spin_ev(0, 127);
         tick();
      end
      frame();
      chk("clamp_hi", pos_of(0), 240);

      // out-of-range position clamped only at the next update
      bus.clamp_en[0] = 1'b0;
      spin_ev(0, 20);
      tick();
      frame();
      chk("wrap_past_hi", pos_of(0), 4);
      bus.clamp_en[0] = 1'b1;
      repeat (2) tick();
      chk("no_immediate_clamp", pos_of(0), 4);
      frame();
      chk("zero_motion_clamp", pos_of(0), 16);
      bus.clamp_en[0] = 1'b0;

      // mouse arbitration
      mouse_ev(5);
      tick();
      chk("mouse_sel", sel_of(0), 2);
      spin_ev(0, 3);
      mouse_ev(7);
      tick();
      chk("arb_sel", sel_of(0), 1);
      frame();
      chk("arb_pos", pos_of(0), 24);

      // event coincident with the strobe edge
      tick();
      bus.strobe = 1'b1;
      spin_ev(0, 9);
      tick();
      bus.strobe = 1'b0;
      chk("coinc_now", pos_of(0), 24);
      tick();
      frame();
      chk("coinc_next", pos_of(0), 33);

      // strobe held high gives one update only
      bus.plus[0] = 1'b1;
      tick();
      bus.strobe = 1'b1;
      repeat (4) tick();
      bus.strobe = 1'b0;
      chk("held_strobe", pos_of(0), 34);
      bus.plus[0] = 1'b0;
      tick();

      // pending saturation at +511
      for (int i = 0; i < 40; i++) begin
         spin_ev(0, 127);
         tick();
      end
      frame();
      chk("sat_pos", pos_of(0), 33);
      chk("ch1_untouched", pos_of(1), 44);

      // asynchronous reset mid-frame discards pending motion
      spin_ev(0, 50);
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_pos0", pos_of(0), 0);
      chk("async_rst_pos1", pos_of(1), 0);
      chk("async_rst_sel", int'(bus.src_sel), 0);
      tick();
      reset_n = 1'b1;
      tick();
      frame();
      chk("post_rst_pos0", pos_of(0), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
